// File: rtl/cnnip_mem_arbiter.sv
// cnnip_mem_arbiter: two-requester arbiter for one CNN IP memory port.
// Requester 0 is the CNN controller and requester 1 is the host bus slave.
// Ownership is round-robin with a burst cap. Read data is routed back to the
// requester that issued it, RD_LAT cycles after the accepted read beat.
// Optional build macro CNNIP_ARB_PRIO_EN: fixed priority to requester 0
// (r0 keeps ownership while it requests, r1 is preempted at its burst cap).
module cnnip_mem_arbiter #(
  parameter int AW        = 16,
  parameter int DW        = 32,
  parameter int WEW       = 4,
  parameter int MAX_BURST = 16,
  parameter int RD_LAT    = 1
) (
  input  logic           clk_a,
  input  logic           arstz_aq,
  input  logic           r0_req,
  input  logic [WEW-1:0] r0_we,
  input  logic [AW-1:0]  r0_addr,
  input  logic [DW-1:0]  r0_din,
  output logic           r0_gnt,
  output logic           r0_rvalid,
  input  logic           r1_req,
  input  logic [WEW-1:0] r1_we,
  input  logic [AW-1:0]  r1_addr,
  input  logic [DW-1:0]  r1_din,
  output logic           r1_gnt,
  output logic           r1_rvalid,
  output logic [DW-1:0]  rdata,
  output logic           mem_en,
  output logic [WEW-1:0] mem_we,
  output logic [AW-1:0]  mem_addr,
  output logic [DW-1:0]  mem_din,
  input  logic [DW-1:0]  mem_dout,
  output logic [1:0]     owner
);

  localparam int CW = $clog2(MAX_BURST + 1);

`ifdef CNNIP_ARB_PRIO_EN
  localparam bit PRIO_EN = 1'b1;
`else
  localparam bit PRIO_EN = 1'b0;
`endif

  // Encodings double as the owner status output.
  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_R0   = 2'b01,
    OWN_R1   = 2'b10
  } owner_e;

  owner_e        state_q, state_d;
  logic          ptr_q, ptr_d;         // last granted requester: 0 = r0, 1 = r1
  logic [CW-1:0] cnt_q, cnt_d;         // accepted beats of the current owner
  logic          beat;
  logic          cap_hit;
  logic [RD_LAT-1:0] tag_v_q;          // read-return pipe: valid per stage
  logic [RD_LAT-1:0] tag_id_q;         // read-return pipe: issuing requester

  assign r0_gnt  = (state_q == OWN_R0) && r0_req;
  assign r1_gnt  = (state_q == OWN_R1) && r1_req;
  assign beat    = r0_gnt | r1_gnt;
  assign cap_hit = beat && (cnt_q == CW'(MAX_BURST - 1));
  assign mem_en  = beat;
  assign owner   = state_q;
  assign rdata   = mem_dout;

  assign r0_rvalid = tag_v_q[RD_LAT-1] && !tag_id_q[RD_LAT-1];
  assign r1_rvalid = tag_v_q[RD_LAT-1] &&  tag_id_q[RD_LAT-1];

  // Ownership register, round-robin pointer and burst counter.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before the edge, independent of block ordering.
  always_ff @(posedge clk_a or negedge arstz_aq) begin
    if (!arstz_aq) begin
      state_q <= OWN_NONE;
      ptr_q   <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next owner, pointer and beat count.
  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    if (beat) cnt_d = cap_hit ? '0 : cnt_q + CW'(1);
    unique case (state_q)
      OWN_NONE: begin
        if (r0_req && r1_req) state_d = (PRIO_EN || ptr_q) ? OWN_R0 : OWN_R1;
        else if (r0_req)      state_d = OWN_R0;
        else if (r1_req)      state_d = OWN_R1;
      end
      OWN_R0: begin
        if (!r0_req)                             state_d = r1_req ? OWN_R1 : OWN_NONE;
        else if (cap_hit && r1_req && !PRIO_EN)  state_d = OWN_R1;
      end
      OWN_R1: begin
        if (!r1_req)                  state_d = r0_req ? OWN_R0 : OWN_NONE;
        else if (cap_hit && r0_req)   state_d = OWN_R0;
      end
      default: state_d = OWN_NONE;
    endcase
    // Any change of owner restarts the burst and moves the pointer to the newcomer.
    if (state_d != state_q) begin
      cnt_d = '0;
      if (state_d == OWN_R0)      ptr_d = 1'b0;
      else if (state_d == OWN_R1) ptr_d = 1'b1;
    end
  end

  // Command mux: drive the granted requester's fields, zero otherwise.
  always_comb begin
    mem_we   = '0;
    mem_addr = '0;
    mem_din  = '0;
    if (r0_gnt) begin
      mem_we   = r0_we;
      mem_addr = r0_addr;
      mem_din  = r0_din;
    end else if (r1_gnt) begin
      mem_we   = r1_we;
      mem_addr = r1_addr;
      mem_din  = r1_din;
    end
  end

  // Read-return tag pipe: one tag per cycle, so in-flight reads survive owner switches.
  // NOTE: the pipe is reset on purpose so reads in flight at reset never
  // produce an rvalid afterwards.
  always_ff @(posedge clk_a or negedge arstz_aq) begin
    if (!arstz_aq) begin
      tag_v_q  <= '0;
      tag_id_q <= '0;
    end else begin
      tag_v_q[0]  <= beat && (mem_we == '0);
      tag_id_q[0] <= r1_gnt;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_v_q[i]  <= tag_v_q[i-1];
        tag_id_q[i] <= tag_id_q[i-1];
      end
    end
  end

endmodule

// File: tb/tb_cnnip_mem_arbiter.sv
// tb_cnnip_mem_arbiter: scoreboard bench for cnnip_mem_arbiter with a memory model.
// Expected read data is queued per requester when a read command is queued.
module tb_cnnip_mem_arbiter;

  localparam int AW = 16, DW = 32, WEW = 4, MAX_BURST = 16, RD_LAT = 1;
`ifdef CNNIP_ARB_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  typedef struct packed {
    logic [WEW-1:0] we;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  din;
  } cmd_t;

  logic clk_a = 1'b0, arstz_aq = 1'b0;
  logic r0_req = 0, r1_req = 0;
  logic [WEW-1:0] r0_we = '0, r1_we = '0;
  logic [AW-1:0]  r0_addr = '0, r1_addr = '0;
  logic [DW-1:0]  r0_din = '0, r1_din = '0;
  logic r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, mem_en;
  logic [DW-1:0]  rdata, mem_din, mem_dout;
  logic [WEW-1:0] mem_we;
  logic [AW-1:0]  mem_addr;
  logic [1:0]     owner;

  cmd_t q0[$], q1[$];
  logic [DW-1:0] exp0[$], exp1[$];
  logic [DW-1:0] mem    [0:16383];
  logic [DW-1:0] shadow [0:16383];
  logic [DW-1:0] dpipe  [RD_LAT];
  int   glog[$];
  bit   log_en = 0, acc0 = 0, acc1 = 0;
  int   n_total = 0, n_bad = 0;

  cnnip_mem_arbiter #(.AW(AW), .DW(DW), .WEW(WEW), .MAX_BURST(MAX_BURST), .RD_LAT(RD_LAT)) dut (
    .clk_a(clk_a), .arstz_aq(arstz_aq),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_din(r0_din),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_din(r1_din),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout), .owner(owner)
  );

  always #5 clk_a = ~clk_a;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int k);
    logic [15:0] kk;
    kk = k[15:0];
    return {kk ^ 16'h5A5A, ~kk};
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] din,
                                          input logic [WEW-1:0] we);
    logic [DW-1:0] w;
    w = old;
    for (int b = 0; b < WEW; b++) if (we[b]) w[8*b +: 8] = din[8*b +: 8];
    return w;
  endfunction

  // Queue a command for requester id; reads queue their expected data now.
  task automatic push_cmd(input int id, input logic [WEW-1:0] we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] din);
    cmd_t c;
    c.we = we; c.addr = addr; c.din = din;
    if (we == '0) begin
      if (id == 0) exp0.push_back(shadow[addr[15:2]]);
      else         exp1.push_back(shadow[addr[15:2]]);
    end else begin
      shadow[addr[15:2]] = merge(shadow[addr[15:2]], din, we);
    end
    if (id == 0) q0.push_back(c); else q1.push_back(c);
  endtask

  // Memory model with RD_LAT read latency.
  initial for (int k = 0; k < 16384; k++) begin mem[k] = pat(k); shadow[k] = pat(k); end
  always @(posedge clk_a) begin
    if (mem_en && mem_we != '0) mem[mem_addr[15:2]] <= merge(mem[mem_addr[15:2]], mem_din, mem_we);
    dpipe[0] <= (mem_en && mem_we == '0) ? mem[mem_addr[15:2]] : '0;
    for (int i = 1; i < RD_LAT; i++) dpipe[i] <= dpipe[i-1];
  end
  assign mem_dout = dpipe[RD_LAT-1];

  // Requester drivers: retire the head after a grant, then present the next head.
  always @(posedge clk_a) begin
    #1;
    if (acc0 && q0.size() != 0) q0.delete(0);
    if (acc1 && q1.size() != 0) q1.delete(0);
    acc0 = 0; acc1 = 0;
    r0_req = (q0.size() != 0);
    if (r0_req) begin r0_we = q0[0].we; r0_addr = q0[0].addr; r0_din = q0[0].din; end
    else begin r0_we = '0; r0_addr = '0; r0_din = '0; end
    r1_req = (q1.size() != 0);
    if (r1_req) begin r1_we = q1[0].we; r1_addr = q1[0].addr; r1_din = q1[0].din; end
    else begin r1_we = '0; r1_addr = '0; r1_din = '0; end
  end

  // Monitor: command bus, exclusivity and read-data scoreboard.
  always @(negedge clk_a) begin
    acc0 = r0_gnt; acc1 = r1_gnt;
    if (log_en) glog.push_back(r0_gnt ? 0 : (r1_gnt ? 1 : 2));
    if (r0_gnt && r1_gnt) check("dual_gnt", {r0_gnt, r1_gnt}, 2'b00);
    if (r0_gnt) begin
      if (q0.size() == 0) check("gnt0_idle", r0_gnt, 0);
      else check("cmd0", {mem_en, mem_we, mem_addr, mem_din}, {1'b1, q0[0]});
    end else if (r1_gnt) begin
      if (q1.size() == 0) check("gnt1_idle", r1_gnt, 0);
      else check("cmd1", {mem_en, mem_we, mem_addr, mem_din}, {1'b1, q1[0]});
    end else begin
      check("idle_bus", {mem_en, mem_we, mem_addr, mem_din}, 53'd0);
    end
    if (r0_rvalid && r1_rvalid) check("dual_rv", {r0_rvalid, r1_rvalid}, 2'b00);
    if (r0_rvalid) begin
      if (exp0.size() == 0) check("rv0_spur", r0_rvalid, 0);
      else check("rd0", rdata, exp0.pop_front());
    end
    if (r1_rvalid) begin
      if (exp1.size() == 0) check("rv1_spur", r1_rvalid, 0);
      else check("rd1", rdata, exp1.pop_front());
    end
  end

  task automatic do_reset();
    arstz_aq = 1'b0;
    q0.delete(); q1.delete(); exp0.delete(); exp1.delete();
    repeat (2) @(negedge clk_a);
    check("rst_out", {r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, mem_en, mem_we, mem_addr, mem_din, owner}, 0);
  endtask

  task automatic do_release();
    @(negedge clk_a);
    arstz_aq = 1'b1;
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q0.size() + q1.size() + exp0.size() + exp1.size()) != 0 && n < 500) begin
      @(negedge clk_a); n++;
    end
    repeat (3) @(negedge clk_a);
    check("drain", q0.size() + q1.size() + exp0.size() + exp1.size(), 0);
  endtask

  task automatic wait_gnt(input int id);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk_a);
      if ((id == 0 && r0_gnt) || (id == 1 && r1_gnt)) break;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int run, c0, c1, g;

    // 1: r0 reads alone; first grant one cycle after ownership is decided.
    do_reset();
    for (int k = 0; k < 4; k++) push_cmd(0, 4'h0, 16'h1000 + 16'(4 * k), '0);
    do_release();
    check("t1_decide_gnt", r0_gnt, 0);
    check("t1_decide_own", owner, 2'b00);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_a);
      check("t1_gnt", r0_gnt, 1);
      check("t1_owner", owner, 2'b01);
      check("t1_rv", r0_rvalid, (k > 0) ? 1 : 0);
    end
    @(negedge clk_a);
    check("t1_gnt_end", r0_gnt, 0);
    check("t1_rv_last", r0_rvalid, 1);
    wait_idle();

`ifndef CNNIP_ARB_PRIO_EN
    // 2: both request from reset: strict 16-beat alternation, r0 first.
    do_reset();
    for (int k = 0; k < 40; k++) push_cmd(0, 4'h0, 16'h1000 + 16'(4 * k), '0);
    for (int k = 0; k < 20; k++) push_cmd(1, 4'h0, 16'h2000 + 16'(4 * k), '0);
    glog.delete();
    do_release();
    log_en = 1;
    for (int n = 0; n < 100 && glog.size() < 48; n++) @(negedge clk_a);
    log_en = 0;
    check("t2_len", glog.size() >= 48, 1);
    for (int i = 0; i < 48 && i < glog.size(); i++) check("t2_seq", glog[i], (i / 16) % 2);
    wait_idle();
`else
    // 6a: priority build: r1 never granted while r0 keeps requesting.
    do_reset();
    for (int k = 0; k < 30; k++) push_cmd(0, 4'h0, 16'h1000 + 16'(4 * k), '0);
    for (int k = 0; k < 30; k++) push_cmd(1, 4'hF, 16'h3400 + 16'(4 * k), 32'hC0DE_0000 + k);
    do_release();
    c0 = 0; c1 = 0;
    repeat (30) begin @(negedge clk_a); c0 += int'(r0_gnt); c1 += int'(r1_gnt); end
    check("t6_r0_cnt", c0, 30);
    check("t6_r1_cnt", c1, 0);
    wait_idle();
    // 6b: r1 alone, r0 raises req: r0 takes over at r1's burst cap.
    do_reset();
    for (int k = 0; k < 20; k++) push_cmd(1, 4'hF, 16'h3500 + 16'(4 * k), 32'hB00C_0000 + k);
    do_release();
    wait_gnt(1);
    for (int k = 0; k < 10; k++) push_cmd(0, 4'h0, 16'h1100 + 16'(4 * k), '0);
    run = 1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk_a);
      if (r1_gnt) run++; else if (r0_gnt) break;
    end
    check("t6_r1_run", run, MAX_BURST);
    wait_idle();
`endif

    // 3: r0 last read, then r1 writes; read-back sees the written data.
    do_reset();
    push_cmd(0, 4'h0, 16'h1010, '0);
    push_cmd(0, 4'h0, 16'h1014, '0);
    do_release();
    for (int n = 0; n < 50; n++) begin
      @(negedge clk_a);
      if (r0_gnt && q0.size() == 1) break;
    end
    push_cmd(1, 4'hF, 16'h3000, 32'hDEADBEEF);
    push_cmd(1, 4'h3, 16'h3004, 32'h1234_5678);
    wait_idle();
    check("t3_mem", mem[16'h3000 >> 2], 32'hDEADBEEF);
    check("t3_mem_be", mem[16'h3004 >> 2], {pat(16'h3004 >> 2) & 32'hFFFF_0000} | 32'h0000_5678);
    push_cmd(0, 4'h0, 16'h3000, '0);
    push_cmd(0, 4'h0, 16'h3004, '0);
    wait_idle();

    // 4: r1 drops after 5 beats with r0 waiting; r0 then gets a fresh burst.
    do_reset();
    for (int k = 0; k < 5; k++) push_cmd(1, 4'hF, 16'h3100 + 16'(4 * k), 32'hA000_0000 + k);
    do_release();
    wait_gnt(1);
    for (int k = 0; k < 20; k++) push_cmd(0, 4'h0, 16'h1200 + 16'(4 * k), '0);
    g = 1;
    for (int n = 0; n < 50 && g < 5; n++) begin @(negedge clk_a); g += int'(r1_gnt); end
    @(negedge clk_a);
    check("t4_gap_own", owner, 2'b10);
    check("t4_gap_gnt", {r0_gnt, r1_gnt}, 2'b00);
    @(negedge clk_a);
    check("t4_new_own", owner, 2'b01);
    check("t4_new_gnt", r0_gnt, 1);
    for (int k = 0; k < 3; k++) push_cmd(1, 4'hF, 16'h3200 + 16'(4 * k), 32'hB000_0000 + k);
    run = 1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk_a);
      if (r0_gnt) run++; else if (r1_gnt) break;
    end
    check("t4_r0_run", run, PRIO ? 20 : MAX_BURST);
    wait_idle();

    // 5: reset with a read in flight: outputs drop at once, nothing returns later.
    do_reset();
    for (int k = 0; k < 8; k++) push_cmd(0, 4'h0, 16'h1300 + 16'(4 * k), '0);
    do_release();
    g = 0;
    for (int n = 0; n < 50 && g < 3; n++) begin @(negedge clk_a); g += int'(r0_gnt); end
    @(posedge clk_a);
    #2;
    arstz_aq = 1'b0;
    #1;
    check("t5_rst_out", {r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, mem_en, mem_we, mem_addr, mem_din, owner}, 0);
    q0.delete(); exp0.delete();
    repeat (2) @(negedge clk_a);
    do_release();
    repeat (4) begin
      @(negedge clk_a);
      check("t5_owner", owner, 2'b00);
      check("t5_rv", {r0_rvalid, r1_rvalid}, 2'b00);
    end
    wait_idle();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
